// File: rtl/window_read_scheduler_if.sv
// -----------------------------------------------------------------------------
// window_read_scheduler_if
// Groups the control handshake and the read-address bus of the window read
// scheduler.
//
// Signals:
//   start      - single-cycle frame request (driven by the controller)
//   stall      - freezes the address sequence (driven by the consumer)
//   read_addr  - SRAM read address (ADDR_W bits)
//   read_valid - read_addr is a newly issued read this cycle
//   row_idx    - kernel row of the current read, 0 = base row (ROW_W bits)
//   col_last   - final row read of a column
//   frame_last - final read of the frame
//   busy       - frame in progress
//   done       - one-cycle end-of-frame pulse
//
// Modports:
//   master - the scheduler (drives the address bus and status)
//   slave  - the controller/consumer (drives start and stall)
// -----------------------------------------------------------------------------
interface window_read_scheduler_if #(
  parameter int ADDR_W = 20,
  parameter int ROW_W  = 4
);

  logic              start;
  logic              stall;
  logic [ADDR_W-1:0] read_addr;
  logic              read_valid;
  logic [ROW_W-1:0]  row_idx;
  logic              col_last;
  logic              frame_last;
  logic              busy;
  logic              done;

  modport master (
    input  start,
    input  stall,
    output read_addr,
    output read_valid,
    output row_idx,
    output col_last,
    output frame_last,
    output busy,
    output done
  );

  modport slave (
    output start,
    output stall,
    input  read_addr,
    input  read_valid,
    input  row_idx,
    input  col_last,
    input  frame_last,
    input  busy,
    input  done
  );

endinterface

// File: rtl/window_read_scheduler.sv
// -----------------------------------------------------------------------------
// window_read_scheduler
// Generates the SRAM read-address sequence feeding the window buffer/shifter.
// For every image column one read is issued per kernel row, walking upward
// through the image: base, base-STRIDE, base-2*STRIDE, ... After the last
// row the column base advances by one, until the column at END_ADDR has been
// read. Each read carries its kernel row index and column/frame-end tags so
// the downstream pipeline can align without counting on its own.
//
// Ports:
//   clk    - system clock, rising edge
//   reset  - synchronous, active-low reset
//   bus    - window_read_scheduler_if.master
//            (start/stall in; read_addr, read_valid, row_idx, col_last,
//             frame_last, busy, done out; all outputs registered)
//
// Parameters:
//   ADDR_W     - read address width
//   ROWS       - kernel height, reads per column (2..16)
//   STRIDE     - address distance between image lines
//   START_ADDR - first column base, must be >= (ROWS-1)*STRIDE
//   END_ADDR   - last column base (inclusive), must be >= START_ADDR
//   ROW_W      - row_idx width, 2**ROW_W >= ROWS
//
// Build option:
//   WINDOW_SCHED_CONTINUOUS_EN - when defined, the scheduler restarts at
//   START_ADDR after the final read of a frame instead of returning to IDLE;
//   busy stays high and done pulses with the first read of the next frame.
//   Only reset leaves that loop.
// -----------------------------------------------------------------------------
module window_read_scheduler #(
  parameter int ADDR_W     = 20,
  parameter int ROWS       = 5,
  parameter int STRIDE     = 256,
  parameter int START_ADDR = 1024,
  parameter int END_ADDR   = 523518,
  parameter int ROW_W      = 4
) (
  input logic                     clk,
  input logic                     reset,
  window_read_scheduler_if.master bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [ADDR_W-1:0] START_A  = ADDR_W'(START_ADDR);
  localparam logic [ADDR_W-1:0] END_A    = ADDR_W'(END_ADDR);
  localparam logic [ADDR_W-1:0] STRIDE_A = ADDR_W'(STRIDE);
  localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(ROWS - 1);

  // Sequencer state
  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;   // base address of the current column
  logic [ROW_W-1:0]  row_q, row_d;     // kernel row of the next read
  // Address of the next read: base - row*STRIDE, maintained by subtracting
  // STRIDE once per row so no multiplier is needed.
  logic [ADDR_W-1:0] cur_q, cur_d;

  // Registered outputs
  logic [ADDR_W-1:0] read_addr_q, read_addr_d;
  logic              read_valid_q, read_valid_d;
  logic [ROW_W-1:0]  row_idx_q, row_idx_d;
  logic              col_last_q, col_last_d;
  logic              frame_last_q, frame_last_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic row_is_last_s;
  logic base_is_end_s;

  // Column / frame boundary decode
  always_comb begin
    row_is_last_s = (row_q == ROW_LAST);
    base_is_end_s = (base_q == END_A);
  end

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    row_d        = row_q;
    cur_d        = cur_q;
    read_addr_d  = read_addr_q;
    read_valid_d = 1'b0;
    row_idx_d    = row_idx_q;
    col_last_d   = 1'b0;
    frame_last_d = 1'b0;
    busy_d       = busy_q;
    done_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          // A simultaneous stall does not block the transition; the first
          // read simply waits in ISSUE until stall drops.
          state_d = ST_ISSUE;
          busy_d  = 1'b1;
          base_d  = START_A;
          row_d   = '0;
          cur_d   = START_A;
        end else begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end

      ST_ISSUE: begin
        busy_d = 1'b1;
`ifdef WINDOW_SCHED_CONTINUOUS_EN
        // The pulse follows the final read of a frame, landing on the first
        // read of the next one.
        done_d = frame_last_q;
`else
        done_d = 1'b0;
`endif
        if (bus.stall) begin
          // Hold everything; read_addr and row_idx keep the last issued read.
          state_d = ST_ISSUE;
        end else begin
          read_addr_d  = cur_q;
          read_valid_d = 1'b1;
          row_idx_d    = row_q;
          col_last_d   = row_is_last_s;
          frame_last_d = row_is_last_s && base_is_end_s;
          if (!row_is_last_s) begin
            row_d = row_q + ROW_W'(1'b1);
            cur_d = cur_q - STRIDE_A;
          end else begin
            row_d = '0;
            if (base_is_end_s) begin
`ifdef WINDOW_SCHED_CONTINUOUS_EN
              state_d = ST_ISSUE;
              base_d  = START_A;
              cur_d   = START_A;
`else
              state_d = ST_DONE;
`endif
            end else begin
              base_d = base_q + ADDR_W'(1'b1);
              cur_d  = base_q + ADDR_W'(1'b1);
            end
          end
        end
      end

      ST_DONE: begin
        // start is not honoured here; only IDLE accepts a new frame.
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      base_q       <= START_A;
      row_q        <= '0;
      cur_q        <= START_A;
      read_addr_q  <= START_A;
      read_valid_q <= 1'b0;
      row_idx_q    <= '0;
      col_last_q   <= 1'b0;
      frame_last_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      row_q        <= row_d;
      cur_q        <= cur_d;
      read_addr_q  <= read_addr_d;
      read_valid_q <= read_valid_d;
      row_idx_q    <= row_idx_d;
      col_last_q   <= col_last_d;
      frame_last_q <= frame_last_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign bus.read_addr  = read_addr_q;
  assign bus.read_valid = read_valid_q;
  assign bus.row_idx    = row_idx_q;
  assign bus.col_last   = col_last_q;
  assign bus.frame_last = frame_last_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule

// File: doc/window_read_scheduler.md
Name: window_read_scheduler

Overview:
Generates the SRAM read-address sequence that feeds the window buffer/shifter pipeline. For each image column it issues one read per kernel row: base, base-STRIDE, base-2*STRIDE, and so on. It then advances the base by one and repeats until END_ADDR. It replaces the fixed 5-row, 256-stride, free-running address case machine with a parametrised block that adds a start/busy/done handshake, a stall input and row/column tags for downstream alignment.

Parameters:
ADDR_W, 20, width of SRAM read address
ROWS, 5, kernel height (reads per column), legal 2..16
STRIDE, 256, address distance between image lines (words)
START_ADDR, 1024, first column base address; must be >= (ROWS-1)*STRIDE
END_ADDR, 523518, last column base address (inclusive); must be >= START_ADDR
ROW_W, 4, width of row_idx; must satisfy 2**ROW_W >= ROWS

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-low reset (asserted when 0)
start  in  1  single-cycle request to begin a frame; honoured only in IDLE
stall  in  1  when 1, freezes the sequence; no address advance, read_valid=0
read_addr  out  ADDR_W  registered SRAM read address
read_valid  out  1  read_addr is a new issued read this cycle
row_idx  out  ROW_W  kernel row of current read, 0 = base row
col_last  out  1  high with the final row read (row_idx==ROWS-1) of every column
frame_last  out  1  high with the final read of the frame
busy  out  1  high from the cycle after start until the final read is issued
done  out  1  one-cycle pulse the cycle after the final read

Behaviour:
- Reset (reset==0 at posedge) has priority over everything, including mid-frame. State goes to IDLE. read_addr=START_ADDR, read_valid=0, row_idx=0, col_last=0, frame_last=0, busy=0, done=0. Internal base=START_ADDR, row counter=0.
- States: IDLE, ISSUE, DONE.
- IDLE: outputs idle (read_valid=0, busy=0). If start==1, go to ISSUE, set busy=1, and load base=START_ADDR, row=0.
- ISSUE, stall==0: on each cycle, register read_addr=base-row*STRIDE, row_idx=row, read_valid=1, col_last=(row==ROWS-1), frame_last=(row==ROWS-1 && base==END_ADDR).
  - If row<ROWS-1, increment row.
  - Otherwise set row=0; if base==END_ADDR go to DONE, else base=base+1.
- ISSUE, stall==1: read_valid=0, col_last=0, frame_last=0. read_addr, row_idx, row and base hold. busy stays 1.
- Stall is sampled in the same cycle it applies. Deasserting it resumes with the exact next address; no read is skipped or repeated.
- DONE: for one cycle, done=1, busy=0, read_valid=0. Next state is IDLE.
- Latency: start sampled at edge N gives the first read_valid (read_addr=START_ADDR, row_idx=0) at edge N+1. With no stall, reads are back-to-back, one per clock.
- Total valid reads per frame = (END_ADDR-START_ADDR+1)*ROWS.
- start while busy or in DONE is ignored; it is not queued.
- Address arithmetic is unsigned ADDR_W. The parameter constraints guarantee no underflow; the implementation does not saturate or wrap-check.
- The multiply row*STRIDE is implemented as an accumulated offset (subtract STRIDE per row). No multiplier is inferred.
- Simultaneous start and stall in IDLE: transition to ISSUE still occurs. The first read is issued on the first edge where stall==0.

Optional Feature:
Macro WINDOW_SCHED_CONTINUOUS_EN.
- Defined: on the final read of a frame, base reloads to START_ADDR and the FSM stays in ISSUE with busy held at 1. done still pulses for one cycle, coincident with the first read of the next frame. Exit from the loop is by reset only.
- Undefined: single-frame behaviour exactly as above (ISSUE -> DONE -> IDLE).

Test Plan:
1. ROWS=5, STRIDE=256, START=1024, END=1026; start pulse, no stall -> 15 consecutive valid reads. Addresses: 1024,768,512,256,0 then 1025,769,513,257,1 then 1026,770,514,258,2. col_last on the 5th, 10th and 15th reads; frame_last on the 15th; done one cycle later; busy low thereafter.
2. Same config with stall=1 for 3 cycles after the 2nd read -> exactly 3 gap cycles with read_valid=0 and read_addr held at 768. Sequence otherwise identical; done is delayed by 3 cycles.
3. ROWS=3, STRIDE=16, START=32, END=33 -> reads 32,16,0,33,17,1 with row_idx 0,1,2,0,1,2; total 6 reads; done at edge 7 after start.
4. reset=0 after the 7th read of scenario 1 -> next cycle read_valid=0, busy=0, read_addr=1024. A later start restarts the sequence from 1024.
5. start pulsed again during the 4th read of scenario 1 -> no effect; exactly 15 reads and a single done pulse.
6. With WINDOW_SCHED_CONTINUOUS_EN, config of scenario 3 -> sequence 32,16,0,33,17,1,32,16,... with no gap. done is high on the cycle issuing the second 32; busy stays 1.
